mem_wb_pipe_stage: RTL
======================

Name: mem_wb_pipe_stage

Overview:
- Parametrised MEM->WB pipeline stage register, next generation of the fixed-width stage register.
- Carries PC, write-back enable, memory-read flag, ALU result, memory read value and destination register index from the MEM stage to the WB stage.
- Adds a valid/ready handshake with a 2-entry skid buffer, so a WB-side stall never combinationally reaches MEM.
- Adds a synchronous flush for bubble insertion.

Parameters:
- PC_W, 32: PC field width.
- DATA_W, 32: ALU result and memory read value width.
- DEST_W, 5: destination register index width.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset; rst=0 resets immediately, independent of clk.
- flush  in  1  synchronous; discards every held and incoming entry.
- valid_in  in  1  MEM-side entry valid.
- ready_out  out  1  stage can accept an entry; driven from a register.
- PC_in  in  PC_W
- WB_en_in  in  1
- MEM_R_EN_in  in  1
- ALU_result_in  in  DATA_W
- Mem_read_value_in  in  DATA_W
- Dest_in  in  DEST_W
- valid_out  out  1  WB-side entry valid.
- ready_in  in  1  WB stage accepts the entry.
- PC  out  PC_W
- WB_en  out  1  stored WB_en AND valid_out.
- MEM_R_EN  out  1
- ALU_result  out  DATA_W
- Mem_read_value  out  DATA_W
- Dest  out  DEST_W

Behaviour:
- Two storage slots: the main slot (drives the outputs) and the skid slot. Each slot holds all six fields plus a valid bit.
- Upstream accept: acc = valid_in & ready_out. Downstream take: take = valid_out & ready_in.
- State machine and transitions (no flush, no reset):
  - EMPTY: main and skid invalid. On acc, load main -> ONE.
  - ONE: main valid, skid invalid.
    - acc & take: main <= input, stay ONE.
    - take only -> EMPTY.
    - acc only: skid <= input -> FULL.
  - FULL: main and skid valid.
    - take: main <= skid, skid invalid -> ONE.
    - Otherwise hold.
- ready_out is a register, 1 in EMPTY and ONE, 0 in FULL. ready_out is registered, so it can never be 1 in FULL and acc cannot occur in FULL.
- Ordering is strict FIFO. No entry is duplicated or dropped except by flush.
- Latency: an entry accepted at edge N appears on the outputs after edge N, i.e. one cycle, when the stage was EMPTY or main was taken at the same edge.
- valid_out = main valid. WB_en output is forced to 0 whenever valid_out=0.
- flush=1 at an edge:
  - Both slots become invalid and the stage goes to EMPTY; ready_out=1 on the next cycle.
  - Data fields hold their previous values.
  - flush has priority over a simultaneous acc (incoming entry dropped) and over take (treated as no transfer).
- Reset (rst=0), including mid-operation in any state:
  - All outputs and fields become 0: PC=0, WB_en=0, MEM_R_EN=0, ALU_result=0, Mem_read_value=0, Dest=0.
  - valid_out=0, ready_out=1, skid slot cleared, state EMPTY.
- After rst rises, the first edge follows normal rules.
- Each field is exactly its parameter width. No truncation or extension inside the stage.

Optional Feature:
- Macro: MEM_WB_FWD_EN.
- When defined, adds three outputs:
  - fwd_valid (1) = valid_out & WB_en & (Dest != 0).
  - fwd_dest (DEST_W) = Dest.
  - fwd_data (DATA_W) = MEM_R_EN ? Mem_read_value : ALU_result.
- The forwarding outputs are combinational from the main slot only; the skid entry is never forwarded.
- When not defined, these ports do not exist and behaviour is otherwise identical.

Test Plan:
- Reset mid-stream: stage FULL, drive rst=0 between edges -> immediately valid_out=0, WB_en=0, all fields 0, ready_out=1; after release, the first accepted entry appears after one edge.
- Streaming: ready_in=1, valid_in=1, PC_in = 0x100, 0x104, 0x108 on consecutive edges -> PC shows the same sequence one cycle later, valid_out stays 1, ready_out stays 1.
- Backpressure: ready_in=0, push PC 0x200 then 0x204 -> ready_out=0 after the second edge; hold 3 cycles (outputs stay 0x200); raise ready_in -> 0x200 is taken, then 0x204 appears, ready_out=1, no loss or duplication.
- Flush collision: state FULL, flush=1 with valid_in=1 (PC 0x300) and ready_in=1 -> next cycle valid_out=0, WB_en=0, ready_out=1; 0x300 never appears.
- Invalid gating: entry with WB_en_in=1 taken with valid_in=0 following -> after take, valid_out=0 and WB_en=0 while data fields hold their previous values.
- Forwarding (MEM_WB_FWD_EN): main slot holds Dest=5, MEM_R_EN=1, Mem_read_value=0xDEAD_BEEF -> fwd_valid=1, fwd_dest=5, fwd_data=0xDEAD_BEEF; Dest=0 -> fwd_valid=0.

Source files
------------

// File: rtl/mem_wb_pipe_stage.sv
// MEM->WB pipeline stage register with valid/ready handshake and a 2-entry
// skid buffer. The main slot drives the WB-side outputs. The skid slot
// catches the one entry that can arrive while WB stalls, because ready_out
// is registered and lags by a cycle.
// Optional feature: define MEM_WB_FWD_EN to add the fwd_valid/fwd_dest/fwd_data
// forwarding outputs, which are taken from the main slot only.
module mem_wb_pipe_stage #(
  parameter int PC_W   = 32,
  parameter int DATA_W = 32,
  parameter int DEST_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic [PC_W-1:0]   PC_in,
  input  logic              WB_en_in,
  input  logic              MEM_R_EN_in,
  input  logic [DATA_W-1:0] ALU_result_in,
  input  logic [DATA_W-1:0] Mem_read_value_in,
  input  logic [DEST_W-1:0] Dest_in,
  output logic              valid_out,
  input  logic              ready_in,
  output logic [PC_W-1:0]   PC,
  output logic              WB_en,
  output logic              MEM_R_EN,
  output logic [DATA_W-1:0] ALU_result,
  output logic [DATA_W-1:0] Mem_read_value,
  output logic [DEST_W-1:0] Dest
`ifdef MEM_WB_FWD_EN
  ,
  output logic              fwd_valid,
  output logic [DEST_W-1:0] fwd_dest,
  output logic [DATA_W-1:0] fwd_data
`endif
);

  // One entry is all six fields concatenated, PC in the top bits
  localparam int ENT_W = PC_W + 2 + 2 * DATA_W + DEST_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state;
  logic [ENT_W-1:0]  main_q;
  logic [ENT_W-1:0]  skid_q;
  logic [ENT_W-1:0]  in_ent;
  logic              main_wb_en;
  logic              acc;
  logic              take;

  assign in_ent = {PC_in, WB_en_in, MEM_R_EN_in, ALU_result_in, Mem_read_value_in, Dest_in};

  assign valid_out = (state != EMPTY);
  assign acc       = valid_in & ready_out;
  assign take      = valid_out & ready_in;

  // Slot occupancy, slot contents and registered ready. The flush and drain
  // paths leave the data fields untouched; only the occupancy changes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= EMPTY;
      ready_out <= 1'b1;
      main_q    <= '0;
      skid_q    <= '0;
    end else if (flush) begin
      state     <= EMPTY;
      ready_out <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (acc) begin
            main_q <= in_ent;
            state  <= ONE;
          end
        end
        ONE: begin
          if (acc && take) begin
            main_q <= in_ent;
          end else if (take) begin
            state <= EMPTY;
          end else if (acc) begin
            skid_q    <= in_ent;
            state     <= FULL;
            ready_out <= 1'b0;
          end
        end
        FULL: begin
          if (take) begin
            main_q    <= skid_q;
            state     <= ONE;
            ready_out <= 1'b1;
          end
        end
        default: begin
          state     <= EMPTY;
          ready_out <= 1'b1;
        end
      endcase
    end
  end

  assign {PC, main_wb_en, MEM_R_EN, ALU_result, Mem_read_value, Dest} = main_q;

  // A held but invalid entry must never request a register write
  assign WB_en = main_wb_en & valid_out;

`ifdef MEM_WB_FWD_EN
  assign fwd_valid = valid_out & WB_en & (Dest != '0);
  assign fwd_dest  = Dest;
  assign fwd_data  = MEM_R_EN ? Mem_read_value : ALU_result;
`endif

endmodule
